// File: rtl/pipe_skid_buffer_pkg.sv
// -----------------------------------------------------------------------------
// pipe_skid_buffer_pkg
//   Shared definitions for the two-entry skid buffer.
//   The state encoding doubles as the occupancy count (EMPTY=0, BUSY=1,
//   FULL=2), so stage controllers and monitors can read either one.
// -----------------------------------------------------------------------------
package pipe_skid_buffer_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

endpackage : pipe_skid_buffer_pkg

// File: rtl/DffPosRst.sv
// -----------------------------------------------------------------------------
// DffPosRst
//   Rising-edge D flop with asynchronous, active-high reset to RST_VALUE.
//   Ports:
//     clk  - clock
//     rst  - asynchronous active-high reset
//     d    - next value
//     q    - registered value
// -----------------------------------------------------------------------------
module DffPosRst #(
  parameter int                    DATA_WIDTH = 1,
  parameter logic [DATA_WIDTH-1:0] RST_VALUE  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VALUE;
    end else begin
      q <= d;
    end
  end

endmodule : DffPosRst

// File: rtl/pipe_skid_buffer.sv
// -----------------------------------------------------------------------------
// pipe_skid_buffer
//   Two-entry valid/ready register slice. Breaks the forward (valid/data) and
//   backward (ready) paths: every output is a flop or a decode of flops only.
//   The main register drives m_data; the skid register catches the one beat
//   that arrives in the cycle after downstream stalls.
//   Ports:
//     clk       - clock, rising edge
//     rst       - asynchronous active-high reset
//     flush     - synchronous discard of all buffered beats
//     s_valid   - upstream beat valid
//     s_ready   - upstream may transfer (from registers only)
//     s_data    - upstream payload
//     m_valid   - downstream beat valid (from registers only)
//     m_ready   - downstream accepts
//     m_data    - downstream payload (main register)
//     occupancy - beats held, 0..2 (the state register itself)
// -----------------------------------------------------------------------------
module pipe_skid_buffer
  import pipe_skid_buffer_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] RST_DATA   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            occupancy
);

  logic [1:0]            state_q;
  logic [1:0]            state_d;
  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] main_d;
  logic [DATA_WIDTH-1:0] skid_q;
  logic [DATA_WIDTH-1:0] skid_d;
  logic                  init_q;
  logic                  up_xfer;
  logic                  dn_xfer;

  // init_q is 0 during reset and the following cycle's first edge sets it;
  // holding s_ready low until then keeps upstream from transferring into a
  // buffer that is still coming out of reset.
  assign s_ready   = init_q & (state_q != ST_FULL);
  assign m_valid   = (state_q != ST_EMPTY);
  assign m_data    = main_q;
  assign occupancy = state_q;

  assign up_xfer = s_valid & s_ready;
  assign dn_xfer = m_valid & m_ready;

  // Next-state and register-enable muxes
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = RST_DATA;
      skid_d  = RST_DATA;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (up_xfer) begin
            main_d  = s_data;
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (up_xfer && dn_xfer) begin
            main_d = s_data;
          end else if (up_xfer) begin
            // Downstream stalled: park the new beat behind the head.
            skid_d  = s_data;
            state_d = ST_FULL;
          end else if (dn_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (dn_xfer) begin
            main_d  = skid_q;
            state_d = ST_BUSY;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Register stage
  DffPosRst #(
    .DATA_WIDTH (2),
    .RST_VALUE  (ST_EMPTY)
  ) u_state (
    .clk (clk),
    .rst (rst),
    .d   (state_d),
    .q   (state_q)
  );

  DffPosRst #(
    .DATA_WIDTH (DATA_WIDTH),
    .RST_VALUE  (RST_DATA)
  ) u_main (
    .clk (clk),
    .rst (rst),
    .d   (main_d),
    .q   (main_q)
  );

  DffPosRst #(
    .DATA_WIDTH (DATA_WIDTH),
    .RST_VALUE  (RST_DATA)
  ) u_skid (
    .clk (clk),
    .rst (rst),
    .d   (skid_d),
    .q   (skid_q)
  );

  DffPosRst #(
    .DATA_WIDTH (1),
    .RST_VALUE  (1'b0)
  ) u_init (
    .clk (clk),
    .rst (rst),
    .d   (1'b1),
    .q   (init_q)
  );

endmodule : pipe_skid_buffer

// File: tb/tb_pipe_skid_buffer.sv
module tb_pipe_skid_buffer;

  localparam int            DW   = 16;
  localparam logic [DW-1:0] RSTV = 16'hDEAD;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [1:0]    occupancy;

  int            tests  = 0;
  int            fails  = 0;
  int            pushed = 0;
  int            popped = 0;
  logic [DW-1:0] sb[$];

  always #5 clk = ~clk;

  pipe_skid_buffer #(
    .DATA_WIDTH (DW),
    .RST_DATA   (RSTV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .occupancy (occupancy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: record handshakes at the edge into the scoreboard, then
  // check the registered outputs #1 after the edge.
  task automatic tick();
    logic          up;
    logic          dn;
    logic          hold;
    logic [DW-1:0] held;
    up   = s_valid && s_ready;
    dn   = m_valid && m_ready;
    hold = m_valid && !m_ready && !flush;
    held = m_data;
    if (dn) begin
      if (sb.size() == 0) begin
        chk("spurious_beat", 32'(m_valid), 32'd0);
      end else begin
        chk("beat_data", 32'(m_data), 32'(sb.pop_front()));
        popped++;
      end
    end
    if (flush) begin
      sb.delete();
    end else if (up) begin
      sb.push_back(s_data);
      pushed++;
    end
    @(posedge clk);
    #1;
    chk("occupancy", 32'(occupancy), 32'(sb.size()));
    chk("m_valid", 32'(m_valid), 32'(sb.size() != 0));
    chk("s_ready", 32'(s_ready), 32'(sb.size() < 2));
    if (sb.size() > 0) chk("m_data_head", 32'(m_data), 32'(sb[0]));
    if (hold) chk("m_data_stable", 32'(m_data), 32'(held));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int   idx;
    int   guard;
    int   p0;
    int   q0;
    logic acc;
    logic sr_snap;

    rst     = 1'b1;
    flush   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_data  = '0;

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'(RSTV));
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("s_ready_before_first_edge", 32'(s_ready), 32'd0);
    tick();
    chk("s_ready_first_edge", 32'(s_ready), 32'd1);

    // Reset mid-stream with two beats held
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'h1234;
    tick();
    s_data  = 16'h5678;
    tick();
    s_valid = 1'b0;
    chk("pre_reset_occupancy", 32'(occupancy), 32'd2);
    chk("pre_reset_m_data", 32'(m_data), 32'h1234);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_m_valid", 32'(m_valid), 32'd0);
    chk("async_rst_occupancy", 32'(occupancy), 32'd0);
    chk("async_rst_m_data", 32'(m_data), 32'(RSTV));
    chk("async_rst_s_ready", 32'(s_ready), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("s_ready_after_deassert", 32'(s_ready), 32'd0);
    tick();
    chk("s_ready_edge_after_deassert", 32'(s_ready), 32'd1);

    // Streaming with m_ready held high
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(i);
      tick();
      chk("stream_data", 32'(m_data), 32'(i));
      chk("stream_occupancy", 32'(occupancy), 32'd1);
    end
    s_valid = 1'b0;
    tick();

    // Backpressure: stall 4 cycles once 0xA2 is at the output
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(16'hA0 + i);
      tick();
    end
    chk("bp_head", 32'(m_data), 32'hA2);
    m_ready = 1'b0;
    s_data  = 16'hA3;
    tick();
    chk("bp_occupancy_full", 32'(occupancy), 32'd2);
    chk("bp_s_ready_low", 32'(s_ready), 32'd0);
    chk("bp_head_held", 32'(m_data), 32'hA2);
    s_data = 16'hA4;
    repeat (3) tick();
    chk("bp_still_full", 32'(occupancy), 32'd2);
    m_ready = 1'b1;
    idx     = 4;
    guard   = 0;
    while ((idx < 16 || sb.size() != 0) && guard < 64) begin
      s_valid = (idx < 16);
      s_data  = DW'(16'hA0 + idx);
      acc     = s_valid && s_ready;
      tick();
      if (acc) idx++;
      guard++;
    end
    chk("bp_drain_in_budget", 32'(guard < 64), 32'd1);
    s_valid = 1'b0;

    // Flush while FULL with downstream ready
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'h0011;
    tick();
    s_data  = 16'h0022;
    tick();
    chk("flush_pre_full", 32'(occupancy), 32'd2);
    s_valid = 1'b0;
    flush   = 1'b1;
    m_ready = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_m_valid", 32'(m_valid), 32'd0);
    chk("flush_occupancy", 32'(occupancy), 32'd0);
    chk("flush_s_ready", 32'(s_ready), 32'd1);
    chk("flush_m_data", 32'(m_data), 32'(RSTV));
    s_valid = 1'b1;
    s_data  = 16'h0055;
    tick();
    s_valid = 1'b0;
    chk("post_flush_beat", 32'(m_data), 32'h0055);
    tick();
    chk("post_flush_empty", 32'(occupancy), 32'd0);

    // Random valid/ready toggling against the scoreboard
    p0 = pushed;
    q0 = popped;
    for (int c = 0; c < 10000; c++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = DW'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      if ((c % 16) == 0) begin
        sr_snap = s_ready;
        m_ready = ~m_ready;
        #1;
        chk("s_ready_indep_m_ready", 32'(s_ready), 32'(sr_snap));
        m_ready = ~m_ready;
      end
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (3) tick();
    chk("random_drained", 32'(occupancy), 32'd0);
    chk("random_count", 32'(popped - q0), 32'(pushed - p0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_pipe_skid_buffer
